// File: rtl/sti4_share_gen.sv
// sti4_share_gen: splits an unmasked nibble into three Boolean shares into a 2-entry output buffer
// Ports: clk/rst_n (sync active-low); in_valid/in_ready/in_data nibble handshake;
//        rnd_valid/rnd_ready/rnd randomness handshake; out_valid/out_ready head-entry handshake;
//        sh = {s2,s1,s0}; f0/f1/f2 non-complete operand buses; acc_cnt saturating accept count;
//        rnd_starve sticky flag for a nibble offered without randomness.
module sti4_share_gen (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_data,
   input  logic        rnd_valid,
   output logic        rnd_ready,
   input  logic [7:0]  rnd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] sh,
   output logic [7:0]  f0,
   output logic [7:0]  f1,
   output logic [7:0]  f2,
   output logic [15:0] acc_cnt,
   output logic        rnd_starve
);
   logic [11:0] mem [2];
   logic [11:0] lst;
   logic        wp, rp;
   logic [1:0]  cnt;
   logic        acc, pop;
   logic [11:0] nsh;
   assign in_ready  = (cnt != 2'd2) & rst_n;
   assign rnd_ready = in_valid & in_ready;
   assign acc       = rnd_ready & rnd_valid;
   assign out_valid = cnt != 2'd0;
   assign pop       = out_valid & out_ready;
   assign nsh       = {in_data ^ rnd[3:0] ^ rnd[7:4], rnd[7:4], rnd[3:0]};
   // an empty buffer keeps presenting the last popped entry
   assign sh = out_valid ? mem[rp] : lst;
   assign f0 = {sh[7:4], sh[11:8]};
   assign f1 = {sh[11:8], sh[3:0]};
   assign f2 = {sh[3:0], sh[7:4]};
   always_ff @(posedge clk)
      if (!rst_n) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         lst        <= '0;
         wp         <= 1'b0;
         rp         <= 1'b0;
         cnt        <= 2'd0;
         acc_cnt    <= '0;
         rnd_starve <= 1'b0;
      end else begin
         if (acc) mem[wp] <= nsh;
         if (pop) lst <= mem[rp];
         wp         <= wp ^ acc;
         rp         <= rp ^ pop;
         cnt        <= cnt + {1'b0, acc} - {1'b0, pop};
         acc_cnt    <= acc_cnt + {15'd0, acc & ~&acc_cnt};
         rnd_starve <= rnd_starve | (in_valid & in_ready & ~rnd_valid);
      end
endmodule

// File: tb/tb_sti4_share_gen.sv
// tb_sti4_share_gen: scoreboard bench for sti4_share_gen
module tb_sti4_share_gen;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, rnd_valid, out_ready;
   logic [3:0]  in_data;
   logic [7:0]  rnd;
   logic        in_ready, rnd_ready, out_valid, rnd_starve;
   logic [11:0] sh;
   logic [7:0]  f0, f1, f2;
   logic [15:0] acc_cnt;
   typedef struct packed { logic [3:0] d; logic [7:0] r; } item_t;
   item_t q [$];
   int total = 0;
   int bad = 0;
   int pops = 0;
   sti4_share_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd), .out_valid(out_valid),
      .out_ready(out_ready), .sh(sh), .f0(f0), .f1(f1), .f2(f2), .acc_cnt(acc_cnt),
      .rnd_starve(rnd_starve)
   );
   always #5 clk = ~clk;
   function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction
   function automatic logic [11:0] shares(item_t e);
      return {e.d ^ e.r[3:0] ^ e.r[7:4], e.r[7:4], e.r[3:0]};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [3:0] d, input logic [7:0] r);
      item_t e;
      in_data = d;
      rnd = r;
      in_valid = 1'b1;
      rnd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.d = d;
            e.r = r;
            q.push_back(e);
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      check("send_timeout", 16'd1, 16'd0);
      in_valid = 1'b0;
   endtask
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) check("spurious_pop", {4'd0, sh}, 16'hFFFF);
         else begin
            item_t e;
            logic [11:0] x;
            e = q.pop_front();
            x = shares(e);
            pops++;
            check("sh", {4'd0, sh}, {4'd0, x});
            check("f0", {8'd0, f0}, {8'd0, x[7:4], x[11:8]});
            check("f1", {8'd0, f1}, {8'd0, x[11:8], x[3:0]});
            check("f2", {8'd0, f2}, {8'd0, x[3:0], x[7:4]});
            check("unmask", {12'd0, sh[3:0] ^ sh[7:4] ^ sh[11:8]}, {12'd0, e.d});
         end
      end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      logic [11:0] hold;
      time t0;
      rst_n = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; in_data = 4'h0; rnd = 8'h00; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_in_ready", {15'd0, in_ready}, 16'd0);
         check("rst_rnd_ready", {15'd0, rnd_ready}, 16'd0);
         check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      end
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);
      check("post_rst_acc", acc_cnt, 16'd0);
      check("post_rst_sh", {4'd0, sh}, 16'd0);
      check("post_rst_f0", {8'd0, f0}, 16'd0);
      check("post_rst_starve", {15'd0, rnd_starve}, 16'd0);
      in_valid = 1'b1; rnd_valid = 1'b0;
      #1;
      check("post_rst_rnd_ready", {15'd0, rnd_ready}, 16'd1);
      in_valid = 1'b0; rnd_valid = 1'b1;
      tick();
      send(4'hA, 8'h35);
      check("single_valid", {15'd0, out_valid}, 16'd1);
      check("single_sh", {4'd0, sh}, 16'h0C35);
      check("single_f0", {8'd0, f0}, 16'h003C);
      check("single_f1", {8'd0, f1}, 16'h00C5);
      check("single_f2", {8'd0, f2}, 16'h0053);
      check("single_acc", acc_cnt, 16'd1);
      tick();
      check("single_drained", {15'd0, out_valid}, 16'd0);
      check("single_hold_sh", {4'd0, sh}, 16'h0C35);
      out_ready = 1'b0;
      send(4'h1, 8'h9E);
      send(4'h2, 8'h47);
      check("bp_full_in_ready", {15'd0, in_ready}, 16'd0);
      hold = sh;
      check("bp_head", {4'd0, sh}, {4'd0, 4'h1 ^ 4'hE ^ 4'h9, 8'h9E});
      in_data = 4'h3; rnd = 8'hB2; in_valid = 1'b1; rnd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", {15'd0, in_ready}, 16'd0);
         check("bp_rnd_ready", {15'd0, rnd_ready}, 16'd0);
         check("bp_stable", {4'd0, sh}, {4'd0, hold});
         check("bp_valid", {15'd0, out_valid}, 16'd1);
         tick();
      end
      check("bp_acc", acc_cnt, 16'd3);
      out_ready = 1'b1;
      send(4'h3, 8'hB2);
      repeat (3) tick();
      check("bp_pops", pops[15:0], 16'd4);
      check("bp_empty", {15'd0, out_valid}, 16'd0);
      in_data = 4'h5; in_valid = 1'b1; rnd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("starve_rnd_ready", {15'd0, rnd_ready}, 16'd1);
         tick();
      end
      check("starve_acc", acc_cnt, 16'd4);
      check("starve_flag", {15'd0, rnd_starve}, 16'd1);
      check("starve_no_out", {15'd0, out_valid}, 16'd0);
      in_valid = 1'b0; rnd_valid = 1'b1;
      tick();
      check("starve_sticky", {15'd0, rnd_starve}, 16'd1);
      for (int i = 0; i < 16; i++) begin
         t0 = $time;
         send(i[3:0], 8'($urandom));
         check("stream_rate", 16'($time - t0), 16'd10);
      end
      repeat (3) tick();
      check("stream_acc", acc_cnt, 16'd20);
      check("stream_pops", pops[15:0], 16'd20);
      out_ready = 1'b0;
      send(4'h7, 8'h12);
      send(4'h8, 8'hC4);
      check("mid_full", {15'd0, in_ready}, 16'd0);
      rst_n = 1'b0;
      q.delete();
      tick();
      check("mid_out_valid", {15'd0, out_valid}, 16'd0);
      check("mid_acc", acc_cnt, 16'd0);
      check("mid_sh", {4'd0, sh}, 16'd0);
      check("mid_in_ready", {15'd0, in_ready}, 16'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_no_ghost", {15'd0, out_valid}, 16'd0);
      end
      check("final_pops", pops[15:0], 16'd20);
      check("final_queue", 16'(q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
